// File: rtl/ibex_bus_responder.sv
// Memory-side responder for one Ibex req/gnt/rvalid bus port.
// A word-addressed SRAM sits behind a grant-delay counter, an outstanding
// limiter and a fixed-latency in-order response pipeline. Accesses outside
// the window get an error response with zero data.
// Optional feature: define IBEX_BUS_RESP_INTG_EN to drive rdata_intg_o with
// prim_secded_inv_39_32_enc check bits of rdata_o; otherwise it is tied to 0.
module ibex_bus_responder #(
  parameter int unsigned MemWords       = 4096,
  parameter logic [31:0] BaseAddr       = 32'h0010_0000,
  parameter int unsigned GntDelay       = 0,
  parameter int unsigned RspLatency     = 1,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic [6:0]  rdata_intg_o,
  output logic        err_o,
  input  logic        stall_i
);

  localparam int unsigned AW        = (MemWords > 1) ? $clog2(MemWords) : 1;
  localparam logic [2:0]  GntDelayC = 3'(GntDelay);
  localparam logic [2:0]  MaxOutC   = 3'(MaxOutstanding);
  localparam logic [31:0] MemWordsC = 32'(MemWords);

  logic [31:0]   offset;
  logic          in_range;
  logic [AW-1:0] idx;

  logic [2:0]    dcnt_q, dcnt_d;
  logic [2:0]    outst_q, outst_d;
  logic          slot_free;
  logic          gnt;

  logic [31:0]   mem_q [MemWords];

  logic [31:0]   rsp_data_d;
  logic          rsp_err_d;

  logic          vld_q  [RspLatency];
  logic [31:0]   data_q [RspLatency];
  logic          err_q  [RspLatency];
  logic          rsp_last;

  // Address decode: the offset wraps below BaseAddr, so the lower bound is
  // checked explicitly rather than relying on the word-count compare.
  assign offset   = addr_i - BaseAddr;
  assign in_range = (addr_i >= BaseAddr) && ((offset >> 2) < MemWordsC);
  assign idx      = offset[AW+1:2];

  // A response leaving the pipeline this cycle frees its slot for a grant in
  // the same cycle, which keeps back-to-back throughput at the limit.
  assign rsp_last  = vld_q[RspLatency-1];
  assign slot_free = (outst_q < MaxOutC) || rsp_last;

  // Reset is folded in so no grant can be seen while the block is held.
  assign gnt   = rst_ni && req_i && (dcnt_q == GntDelayC) && !stall_i && slot_free;
  assign gnt_o = gnt;

  // Grant-delay counter: counts cycles of an ungranted request, saturating.
  always_comb begin
    dcnt_d = dcnt_q;
    if (!req_i || gnt) begin
      dcnt_d = 3'd0;
    end else if (dcnt_q < GntDelayC) begin
      dcnt_d = dcnt_q + 3'd1;
    end
  end

  // Outstanding count: one up per grant, one down per delivered response.
  always_comb begin
    outst_d = outst_q + {2'b00, gnt} - {2'b00, rsp_last};
  end

  // Control state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dcnt_q  <= 3'd0;
      outst_q <= 3'd0;
    end else begin
      dcnt_q  <= dcnt_d;
      outst_q <= outst_d;
    end
  end

  // Byte-masked array write; contents deliberately survive reset.
  always_ff @(posedge clk_i) begin
    if (gnt && we_i && in_range) begin
      for (int k = 0; k < 4; k++) begin
        if (be_i[k]) begin
          mem_q[idx][8*k +: 8] <= wdata_i[8*k +: 8];
        end
      end
    end
  end

  // Response payload captured at grant; a read sees the pre-write word.
  always_comb begin
    rsp_err_d  = !in_range;
    rsp_data_d = 32'h0;
    if (in_range && !we_i) begin
      rsp_data_d = mem_q[idx];
    end
  end

  // Response pipeline. Payload only moves behind a valid entry, so the last
  // stage keeps the previous response while rvalid_o is low.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < RspLatency; i++) begin
        vld_q[i]  <= 1'b0;
        data_q[i] <= 32'h0;
        err_q[i]  <= 1'b0;
      end
    end else begin
      vld_q[0] <= gnt;
      if (gnt) begin
        data_q[0] <= rsp_data_d;
        err_q[0]  <= rsp_err_d;
      end
      for (int unsigned i = 1; i < RspLatency; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) begin
          data_q[i] <= data_q[i-1];
          err_q[i]  <= err_q[i-1];
        end
      end
    end
  end

  assign rvalid_o = rsp_last;
  assign rdata_o  = data_q[RspLatency-1];
  assign err_o    = err_q[RspLatency-1];

`ifdef IBEX_BUS_RESP_INTG_EN
  // The inverted code maps an all-zero word to non-zero check bits; this is
  // the value presented with the reset-state rdata_o of zero.
  localparam logic [6:0] IntgZero = 7'h2A;

  logic [38:0] enc_out;
  logic [6:0]  intg_q [RspLatency];
  logic        unused_enc_data;

  prim_secded_inv_39_32_enc u_intg_enc (
    .data_i (rsp_data_d),
    .data_o (enc_out)
  );

  assign unused_enc_data = ^enc_out[31:0];

  // Check bits travel alongside their data so they always match rdata_o.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < RspLatency; i++) begin
        intg_q[i] <= IntgZero;
      end
    end else begin
      if (gnt) begin
        intg_q[0] <= enc_out[38:32];
      end
      for (int unsigned i = 1; i < RspLatency; i++) begin
        if (vld_q[i-1]) begin
          intg_q[i] <= intg_q[i-1];
        end
      end
    end
  end

  assign rdata_intg_o = intg_q[RspLatency-1];
`else
  assign rdata_intg_o = 7'b0;
`endif

endmodule

// File: tb/tb_ibex_bus_responder.sv
// Bench for ibex_bus_responder: three instances with different grant delay /
// latency settings, checked every cycle against a transaction-level model
// (byte array, FIFO of due responses, request hold counter).
module tb_ibex_bus_responder;

  localparam int          N    = 3;
  localparam int          MW   = 16;
  localparam logic [31:0] BASE = 32'h0010_0000;
  localparam int          GD   [N] = '{0, 3, 0};
  localparam int          LAT  [N] = '{1, 2, 4};
  localparam int          MAXO [N] = '{2, 2, 2};

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req [N];
  logic        we [N];
  logic        stall [N];
  logic [3:0]  be [N];
  logic [31:0] addr [N];
  logic [31:0] wdata [N];
  logic        gnt [N];
  logic        rvalid [N];
  logic        err [N];
  logic [31:0] rdata [N];
  logic [6:0]  intg [N];

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  // reference model state
  logic [31:0] mem_m [N][MW];
  int          due_b [N][8];
  logic [31:0] dat_b [N][8];
  logic        err_b [N][8];
  int          head [N];
  int          tail [N];
  int          hold [N];
  logic [31:0] last_d [N];
  logic        last_e [N];

  ibex_bus_responder #(.MemWords(MW), .BaseAddr(BASE), .GntDelay(0), .RspLatency(1),
                       .MaxOutstanding(2)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[0]), .gnt_o(gnt[0]), .rvalid_o(rvalid[0]),
    .we_i(we[0]), .be_i(be[0]), .addr_i(addr[0]), .wdata_i(wdata[0]), .rdata_o(rdata[0]),
    .rdata_intg_o(intg[0]), .err_o(err[0]), .stall_i(stall[0]));

  ibex_bus_responder #(.MemWords(MW), .BaseAddr(BASE), .GntDelay(3), .RspLatency(2),
                       .MaxOutstanding(2)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[1]), .gnt_o(gnt[1]), .rvalid_o(rvalid[1]),
    .we_i(we[1]), .be_i(be[1]), .addr_i(addr[1]), .wdata_i(wdata[1]), .rdata_o(rdata[1]),
    .rdata_intg_o(intg[1]), .err_o(err[1]), .stall_i(stall[1]));

  ibex_bus_responder #(.MemWords(MW), .BaseAddr(BASE), .GntDelay(0), .RspLatency(4),
                       .MaxOutstanding(2)) u_dut_c (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[2]), .gnt_o(gnt[2]), .rvalid_o(rvalid[2]),
    .we_i(we[2]), .be_i(be[2]), .addr_i(addr[2]), .wdata_i(wdata[2]), .rdata_o(rdata[2]),
    .rdata_intg_o(intg[2]), .err_o(err[2]), .stall_i(stall[2]));

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input int d, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d observed=%h expected=%h cycle=%0d", tag, d, obs, exp, cyc);
    end
  endtask

  // Per-cycle model step for one instance, evaluated on the falling edge.
  task automatic check_dut(input int d);
    logic        exp_rv, exp_g, inr;
    longint      off;
    int          ix;
    logic [31:0] rd;
    if (!rst_n) begin
      chk("rst_gnt", d, 32'(gnt[d]), 32'h0);
      chk("rst_rvalid", d, 32'(rvalid[d]), 32'h0);
      chk("rst_rdata", d, rdata[d], 32'h0);
      chk("rst_err", d, 32'(err[d]), 32'h0);
      head[d] = 0; tail[d] = 0; hold[d] = 0;
      last_d[d] = 32'h0; last_e[d] = 1'b0;
      return;
    end
    exp_rv = (head[d] != tail[d]) && (due_b[d][head[d] % 8] == cyc);
    exp_g  = req[d] && (hold[d] >= GD[d]) && !stall[d] &&
             (((tail[d] - head[d]) < MAXO[d]) || exp_rv);
    chk("gnt", d, 32'(gnt[d]), 32'(exp_g));
    chk("rvalid", d, 32'(rvalid[d]), 32'(exp_rv));
    if (exp_rv) begin
      last_d[d] = dat_b[d][head[d] % 8];
      last_e[d] = err_b[d][head[d] % 8];
      head[d]++;
    end
    chk("rdata", d, rdata[d], last_d[d]);
    chk("err", d, 32'(err[d]), 32'(last_e[d]));
`ifndef IBEX_BUS_RESP_INTG_EN
    chk("intg", d, 32'(intg[d]), 32'h0);
`endif
    if (req[d] && gnt[d]) begin
      off = longint'(addr[d]) - longint'(BASE);
      inr = (off >= 0) && ((off / 4) < MW);
      rd  = 32'h0;
      if (inr) begin
        ix = int'(off / 4);
        if (we[d]) begin
          for (int k = 0; k < 4; k++)
            if (be[d][k]) mem_m[d][ix][8*k +: 8] = wdata[d][8*k +: 8];
        end else begin
          rd = mem_m[d][ix];
        end
      end
      due_b[d][tail[d] % 8] = cyc + LAT[d];
      dat_b[d][tail[d] % 8] = rd;
      err_b[d][tail[d] % 8] = !inr;
      tail[d]++;
    end
    if (req[d] && !gnt[d]) hold[d]++;
    else hold[d] = 0;
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < N; d++) check_dut(d);
  end

  // Present one request and wait for its grant; returns cycles waited.
  task automatic xfer(input int d, input logic w, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] b, output int n);
    req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd; be[d] = b;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!gnt[d] && n < 64);
    chk("granted", d, 32'(gnt[d]), 32'h1);
    @(posedge clk);
    #1;
    req[d] = 1'b0;
  endtask

  task automatic idle(input int k);
    if (k > 0) begin
      repeat (k) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, g, rv;
    int exp_n [4] = '{1, 1, 3, 1};
    logic [31:0] a;
    for (int d = 0; d < N; d++) begin
      req[d] = 1'b0; we[d] = 1'b0; stall[d] = 1'b0; be[d] = 4'h0;
      addr[d] = BASE; wdata[d] = 32'h0;
    end
    // hold a request during reset: it must not be granted
    req[0] = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    req[0] = 1'b0;

    // preload every word so all later reads have known contents
    for (int d = 0; d < N; d++)
      for (int w = 0; w < MW; w++)
        xfer(d, 1'b1, BASE + 32'(4 * w), $urandom, 4'hF, n);
    idle(6);

    // instance A: zero grant delay, single-cycle latency
    xfer(0, 1'b1, BASE, 32'hDEADBEEF, 4'hF, n);
    chk("a_wr_wait", 0, 32'(n), 32'd1);
    xfer(0, 1'b0, BASE, 32'h0, 4'hF, n);
    chk("a_rd_wait", 0, 32'(n), 32'd1);
    idle(2);
    chk("a_rd_data", 0, rdata[0], 32'hDEADBEEF);
    xfer(0, 1'b1, BASE, 32'h0000AB00, 4'b0010, n);
    xfer(0, 1'b0, BASE, 32'h0, 4'hF, n);
    idle(2);
    chk("a_partial", 0, rdata[0], 32'hDEADABEF);
    xfer(0, 1'b0, BASE + 32'(4 * MW), 32'h0, 4'hF, n);
    idle(2);
    chk("a_oor_err", 0, 32'(err[0]), 32'h1);
    chk("a_oor_data", 0, rdata[0], 32'h0);
    xfer(0, 1'b1, BASE + 32'(4 * MW), 32'h11111111, 4'hF, n);
    xfer(0, 1'b1, BASE - 32'd4, 32'h22222222, 4'hF, n);
    xfer(0, 1'b1, BASE, 32'hFFFFFFFF, 4'h0, n);
    xfer(0, 1'b0, BASE, 32'h0, 4'hF, n);
    idle(2);
    chk("a_unchanged", 0, rdata[0], 32'hDEADABEF);
    chk("a_unchanged_err", 0, 32'(err[0]), 32'h0);
    xfer(0, 1'b1, BASE + 32'd8, 32'h12345678, 4'hF, n);
    xfer(0, 1'b0, BASE + 32'd8, 32'h0, 4'hF, n);
    idle(2);
    chk("a_raw", 0, rdata[0], 32'h12345678);

    // instance B: grant delay 3, latency 2, held back-to-back reads
    for (int i = 0; i < 4; i++) begin
      xfer(1, 1'b0, BASE + 32'(4 * i), 32'h0, 4'hF, n);
      chk("b_wait", 1, 32'(n), 32'd4);
    end
    idle(4);

    // randomized traffic on A and B, some addresses outside the window
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 40; i++) begin
        a = BASE + 32'(4 * $urandom_range(0, MW + 1));
        if ($urandom_range(0, 9) == 0) a = BASE - 32'd4;
        xfer(d, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), n);
        idle(int'($urandom_range(0, 2)));
      end
      idle(6);
    end

    // instance C: latency 4 throttled by two outstanding slots
    for (int i = 0; i < 4; i++) begin
      xfer(2, 1'b0, BASE + 32'(4 * i), 32'h0, 4'hF, n);
      chk("c_wait", 2, 32'(n), 32'(exp_n[i]));
    end
    idle(6);
    stall[2] = 1'b1;
    req[2] = 1'b1; we[2] = 1'b0; addr[2] = BASE + 32'd12; be[2] = 4'hF;
    g = 0;
    repeat (5) begin
      @(negedge clk);
      if (gnt[2]) g++;
    end
    @(posedge clk);
    #1;
    stall[2] = 1'b0;
    chk("c_stall_gnts", 2, 32'(g), 32'd0);
    xfer(2, 1'b0, BASE + 32'd12, 32'h0, 4'hF, n);
    chk("c_after_stall", 2, 32'(n), 32'd1);
    idle(6);

    // reset with two reads in flight on C
    xfer(2, 1'b1, BASE + 32'd20, 32'hCAFEF00D, 4'hF, n);
    idle(6);
    xfer(2, 1'b0, BASE + 32'd20, 32'h0, 4'hF, n);
    xfer(2, 1'b0, BASE + 32'd24, 32'h0, 4'hF, n);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rv = 0;
    repeat (8) begin
      @(negedge clk);
      if (rvalid[2]) rv++;
    end
    @(posedge clk);
    #1;
    chk("c_post_rst_rvalid", 2, 32'(rv), 32'd0);
    xfer(2, 1'b0, BASE + 32'd20, 32'h0, 4'hF, n);
    idle(5);
    chk("c_persist", 2, rdata[2], 32'hCAFEF00D);
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
